// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_M2   = 3'd4
  } booth_sel_e;

  function automatic int unsigned iter_count(input int unsigned n);
    return n / 2 + 1;
  endfunction

  // Modified-Booth recoding of {q[i+1], q[i], q[i-1]}.
  function automatic booth_sel_e booth_sel(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_M2;
      3'b101, 3'b110: sel = SEL_M1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational Booth partial-term generator: 3-bit group and Mx -> signed N+3-bit term.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [2:0]   grp,
  input  logic [N+1:0] mx,
  output logic [N+2:0] term_c
);

  localparam int unsigned TW = N + 3;

  logic [N+2:0] mx_ext;
  assign mx_ext = {mx[N+1], mx};

  always_comb begin
    term_c = '0;
    case (booth_sel(grp))
      SEL_P1:  term_c = mx_ext;
      SEL_P2:  term_c = TW'(mx_ext << 1);
      SEL_M1:  term_c = TW'(-mx_ext);
      SEL_M2:  term_c = TW'(-(mx_ext << 1));
      default: term_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, 2 multiplier bits per cycle, signed/unsigned per operation,
// with start/busy/done handshake.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned ITER  = iter_count(N);
  localparam int unsigned QW    = N + 2;
  localparam int unsigned AW    = N + 3;
  localparam int unsigned PW    = 2 * N;
  localparam int unsigned CNT_W = $clog2(ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    a_q, a_d;
  logic [QW-1:0]    qx_q, qx_d;
  logic [QW-1:0]    mx_q, mx_d;
  logic             qm1_q, qm1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;

  logic          accept_c, last_c;
  logic [AW-1:0] term_c, sum_c, a_sh_c;
  logic [QW-1:0] qx_sh_c;

  assign accept_c = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_c   = (state_q == ST_RUN) && (cnt_q == CNT_W'(ITER - 1));

  booth_r4_recoder #(.N(N)) u_recoder (
    .grp    ({qx_q[1:0], qm1_q}),
    .mx     (mx_q),
    .term_c (term_c)
  );

  // Accumulate, then arithmetic shift {A,Qx,q_-1} right by two.
  assign sum_c   = a_q + term_c;
  assign a_sh_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
  assign qx_sh_c = {sum_c[1:0], qx_q[QW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    a_d       = a_q;
    qx_d      = qx_q;
    mx_d      = mx_q;
    qm1_d     = qm1_q;
    product_d = product_q;
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    if (accept_c) begin
      mx_d  = signed_mode ? {{2{m[N-1]}}, m} : {2'b00, m};
      qx_d  = signed_mode ? {{2{q[N-1]}}, q} : {2'b00, q};
      a_d   = '0;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      a_d   = a_sh_c;
      qx_d  = qx_sh_c;
      qm1_d = qx_q[1];
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) product_d = PW'({a_sh_c, qx_sh_c});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      a_q       <= '0;
      qx_q      <= '0;
      mx_q      <= '0;
      qm1_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      qx_q      <= qx_d;
      mx_q      <= mx_d;
      qm1_q     <= qm1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
